// File: rtl/clock_divider_multi_if.sv
// Configuration write channel for clock_divider_multi: per-channel divisor/high-time
// writes with a valid/ready handshake.
interface clock_divider_multi_if #(
    parameter int unsigned N      = 8,
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch;
    logic [N-1:0]    cfg_div;
    logic [N-1:0]    cfg_high;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        output cfg_high,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_high,
        output cfg_ready
    );
endinterface

// File: rtl/clock_divider_multi.sv
// NUM_CH independent programmable clock dividers sharing one input clock. Divisor and
// high-time writes are shadowed and only take effect at a period boundary, sync or disable.
module clock_divider_multi #(
    parameter int unsigned N         = 8,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned RESET_DIV = 2
) (
    input  logic                  clock_in,
    input  logic                  reset_n,
    input  logic [NUM_CH-1:0]     en,
    input  logic                  sync,
    clock_divider_multi_if.slave  cfg,
    output logic [NUM_CH-1:0]     clock_out,
    output logic [NUM_CH-1:0]     tick
);

    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [N-1:0] RST_DIV  = N'(RESET_DIV);
    localparam logic [N-1:0] RST_HIGH = N'(RESET_DIV / 2);

    logic [N-1:0]      cnt_q   [NUM_CH];
    logic [N-1:0]      cnt_d   [NUM_CH];
    logic [N-1:0]      div_q   [NUM_CH];
    logic [N-1:0]      div_d   [NUM_CH];
    logic [N-1:0]      high_q  [NUM_CH];
    logic [N-1:0]      high_d  [NUM_CH];
    logic [N-1:0]      sdiv_q  [NUM_CH];
    logic [N-1:0]      sdiv_d  [NUM_CH];
    logic [N-1:0]      shigh_q [NUM_CH];
    logic [N-1:0]      shigh_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;

    logic [NUM_CH-1:0] run_c;
    logic [NUM_CH-1:0] wrap_c;
    logic [NUM_CH-1:0] wr_c;
    logic              ready_c;

    // Handshake: a channel with a pending shadow refuses new writes; unknown channels are sunk.
    always_comb begin
        ready_c = 1'b1;
        wr_c    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((cfg.cfg_ch == CH_W'(i)) && pend_q[i]) begin
                ready_c = 1'b0;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            wr_c[i] = cfg.cfg_valid && ready_c && (cfg.cfg_ch == CH_W'(i));
        end
    end

    assign cfg.cfg_ready = ready_c;

    always_comb begin
        run_c  = '0;
        wrap_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            run_c[i]  = en[i] && (div_q[i] != '0);
            wrap_c[i] = cnt_q[i] >= (div_q[i] - N'(1));
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        high_d  = high_q;
        sdiv_d  = sdiv_q;
        shigh_d = shigh_q;
        pend_d  = pend_q;
        clk_d   = '0;
        tick_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            clk_d[i] = run_c[i] && (cnt_q[i] < high_q[i]);

            if (wr_c[i]) begin
                sdiv_d[i]  = cfg.cfg_div;
                shigh_d[i] = cfg.cfg_high;
                pend_d[i]  = 1'b1;
            end

            if (sync) begin
                // Restart in phase; a write landing in the sync cycle is applied directly.
                cnt_d[i] = '0;
                if (pend_q[i]) begin
                    div_d[i]  = sdiv_q[i];
                    high_d[i] = shigh_q[i];
                    pend_d[i] = 1'b0;
                end
                if (wr_c[i]) begin
                    div_d[i]  = cfg.cfg_div;
                    high_d[i] = cfg.cfg_high;
                    pend_d[i] = 1'b0;
                end
            end else if (!run_c[i]) begin
                cnt_d[i] = '0;
                if (pend_q[i]) begin
                    div_d[i]  = sdiv_q[i];
                    high_d[i] = shigh_q[i];
                    pend_d[i] = 1'b0;
                end
            end else if (wrap_c[i]) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                if (pend_q[i]) begin
                    div_d[i]  = sdiv_q[i];
                    high_d[i] = shigh_q[i];
                    pend_d[i] = 1'b0;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + N'(1);
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= '0;
                div_q[i]   <= RST_DIV;
                high_q[i]  <= RST_HIGH;
                sdiv_q[i]  <= '0;
                shigh_q[i] <= '0;
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            sdiv_q  <= sdiv_d;
            shigh_q <= shigh_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign clock_out = clk_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: each channel is modelled as a queue holding the
// remaining (clock_out, tick) samples of its current period.
module tb_clock_divider_multi;

    localparam int unsigned N         = 8;
    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned RESET_DIV = 2;
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic [NUM_CH-1:0] clock_out;
    logic [NUM_CH-1:0] tick;

    always #5 clk = ~clk;

    clock_divider_multi_if #(.N(N), .NUM_CH(NUM_CH)) cfg_if ();

    clock_divider_multi #(.N(N), .NUM_CH(NUM_CH), .RESET_DIV(RESET_DIV)) dut (
        .clock_in  (clk),
        .reset_n   (rst_n),
        .en        (en),
        .sync      (sync),
        .cfg       (cfg_if),
        .clock_out (clock_out),
        .tick      (tick)
    );

    int n_vec;
    int n_err;

    // Reference model: active/shadow settings plus the rest of the current period as samples.
    int                m_div   [NUM_CH];
    int                m_high  [NUM_CH];
    int                m_sdiv  [NUM_CH];
    int                m_shigh [NUM_CH];
    bit                m_pend  [NUM_CH];
    bit [1:0]          m_q     [NUM_CH][$];
    logic [NUM_CH-1:0] exp_clk;
    logic [NUM_CH-1:0] exp_tick;

    function automatic bit model_ready(int ch);
        return (ch >= int'(NUM_CH)) || !m_pend[ch];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_q[c].delete();
            m_div[c]   = RESET_DIV;
            m_high[c]  = RESET_DIV / 2;
            m_sdiv[c]  = 0;
            m_shigh[c] = 0;
            m_pend[c]  = 1'b0;
        end
        exp_clk  = '0;
        exp_tick = '0;
    endtask

    task automatic model_refill(int c);
        for (int k = 0; k < m_div[c]; k++) begin
            m_q[c].push_back({(k < m_high[c]), (k == m_div[c] - 1)});
        end
    endtask

    task automatic model_apply(int c);
        if (m_pend[c]) begin
            m_div[c]  = m_sdiv[c];
            m_high[c] = m_shigh[c];
            m_pend[c] = 1'b0;
        end
    endtask

    task automatic model_step();
        int       ch;
        bit       acc;
        bit       wr;
        bit [1:0] e;
        ch  = int'(cfg_if.cfg_ch);
        acc = cfg_if.cfg_valid && (ch < int'(NUM_CH)) && model_ready(ch);
        for (int c = 0; c < NUM_CH; c++) begin
            wr = acc && (ch == c);
            e  = 2'b00;
            if (sync) begin
                if (en[c] && m_div[c] != 0) begin
                    if (m_q[c].size() == 0) model_refill(c);
                    e = m_q[c].pop_front();
                end
                exp_clk[c]  = e[1];
                exp_tick[c] = 1'b0;
                m_q[c].delete();
                model_apply(c);
                if (wr) begin
                    m_div[c]  = int'(cfg_if.cfg_div);
                    m_high[c] = int'(cfg_if.cfg_high);
                end
            end else if (!en[c] || m_div[c] == 0) begin
                exp_clk[c]  = 1'b0;
                exp_tick[c] = 1'b0;
                m_q[c].delete();
                model_apply(c);
                if (wr) begin
                    m_sdiv[c]  = int'(cfg_if.cfg_div);
                    m_shigh[c] = int'(cfg_if.cfg_high);
                    m_pend[c]  = 1'b1;
                end
            end else begin
                if (m_q[c].size() == 0) model_refill(c);
                e = m_q[c].pop_front();
                exp_clk[c]  = e[1];
                exp_tick[c] = e[0];
                if (m_q[c].size() == 0) model_apply(c);
                if (wr) begin
                    m_sdiv[c]  = int'(cfg_if.cfg_div);
                    m_shigh[c] = int'(cfg_if.cfg_high);
                    m_pend[c]  = 1'b1;
                end
            end
        end
    endtask

    // Advance one clock; inputs were driven 1 time unit after the previous edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_cfg(bit valid, int ch, int dv, int hi);
        cfg_if.cfg_valid = valid;
        cfg_if.cfg_ch    = CH_W'(ch);
        cfg_if.cfg_div   = N'(dv);
        cfg_if.cfg_high  = N'(hi);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = '0;
        sync  = 1'b0;
        set_cfg(1'b0, 0, 0, 0);
        model_reset();
        #1;
        n_vec++;
        if (clock_out !== '0 || tick !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: clock_out=%b tick=%b, expected 0000 0000", clock_out, tick);
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: cfg_ready=%b, expected 1", cfg_if.cfg_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_default_div();
        en = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            cycle();
            n_vec++;
            if (clock_out !== exp_clk || tick !== exp_tick) begin
                n_err++;
                $display("FAIL default_div k=%0d: clock_out=%b tick=%b, expected %b %b",
                         k, clock_out, tick, exp_clk, exp_tick);
            end
        end
    endtask

    task automatic test_write_disabled();
        set_cfg(1'b1, 1, 5, 2);
        #1;
        n_vec++;
        if (cfg_if.cfg_ready !== model_ready(1)) begin
            n_err++;
            $display("FAIL wr_dis_ready: cfg_ready=%b, expected %b", cfg_if.cfg_ready, model_ready(1));
        end
        cycle();
        set_cfg(1'b0, 1, 0, 0);
        cycle();
        en = 4'b0011;
        for (int k = 0; k < 16; k++) begin
            cycle();
            n_vec++;
            if (clock_out !== exp_clk || tick !== exp_tick) begin
                n_err++;
                $display("FAIL wr_dis_run k=%0d: clock_out=%b tick=%b, expected %b %b",
                         k, clock_out, tick, exp_clk, exp_tick);
            end
        end
    endtask

    task automatic test_glitch_free();
        int guard;
        en[0] = 1'b0;
        set_cfg(1'b1, 0, 4, 1);
        cycle();
        set_cfg(1'b0, 0, 0, 0);
        cycle();
        en[0] = 1'b1;
        guard = 0;
        // Stop where the next edge sees cnt=1 on ch0 (three samples left in its period).
        do begin
            cycle();
            guard++;
            n_vec++;
            if (clock_out !== exp_clk || tick !== exp_tick) begin
                n_err++;
                $display("FAIL glitch_pre: clock_out=%b tick=%b, expected %b %b",
                         clock_out, tick, exp_clk, exp_tick);
            end
        end while (m_q[0].size() != 3 && guard < 20);
        if (guard >= 20) begin
            n_err++;
            $display("FAIL glitch_align: ch0 never reached cnt=1 within 20 cycles");
        end
        set_cfg(1'b1, 0, 6, 3);
        #1;
        n_vec++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_accept: cfg_ready=%b, expected 1", cfg_if.cfg_ready);
        end
        cycle();
        set_cfg(1'b1, 0, 2, 1);
        #1;
        n_vec++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_block_ch0: cfg_ready=%b, expected 0", cfg_if.cfg_ready);
        end
        cycle();
        set_cfg(1'b1, 2, 3, 1);
        #1;
        n_vec++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_accept_ch2: cfg_ready=%b, expected 1", cfg_if.cfg_ready);
        end
        cycle();
        set_cfg(1'b0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            #1;
            n_vec++;
            if (cfg_if.cfg_ready !== model_ready(0)) begin
                n_err++;
                $display("FAIL glitch_ready k=%0d: cfg_ready=%b, expected %b",
                         k, cfg_if.cfg_ready, model_ready(0));
            end
            cycle();
            n_vec++;
            if (clock_out !== exp_clk || tick !== exp_tick) begin
                n_err++;
                $display("FAIL glitch_run k=%0d: clock_out=%b tick=%b, expected %b %b",
                         k, clock_out, tick, exp_clk, exp_tick);
            end
        end
    endtask

    task automatic test_sync();
        en = '0;
        set_cfg(1'b1, 0, 3, 1);
        cycle();
        set_cfg(1'b1, 1, 7, 3);
        cycle();
        set_cfg(1'b0, 0, 0, 0);
        cycle();
        en = 4'b0001;
        repeat ($urandom_range(1, 6)) cycle();
        en = 4'b0011;
        repeat ($urandom_range(0, 10)) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        for (int k = 0; k < 45; k++) begin
            cycle();
            n_vec++;
            if (clock_out !== exp_clk || tick !== exp_tick) begin
                n_err++;
                $display("FAIL sync_run k=%0d: clock_out=%b tick=%b, expected %b %b",
                         k, clock_out, tick, exp_clk, exp_tick);
            end
        end
    endtask

    task automatic test_boundaries();
        int bd [5] = '{4, 4, 0, 1, 255};
        int bh [5] = '{0, 9, 3, 0, 128};
        int bn [5] = '{12, 12, 8, 6, 520};
        for (int t = 0; t < 5; t++) begin
            en[0] = 1'b0;
            set_cfg(1'b1, 0, bd[t], bh[t]);
            cycle();
            set_cfg(1'b0, 0, 0, 0);
            cycle();
            en[0] = 1'b1;
            for (int k = 0; k < bn[t]; k++) begin
                cycle();
                n_vec++;
                if (clock_out !== exp_clk || tick !== exp_tick) begin
                    n_err++;
                    $display("FAIL boundary D=%0d H=%0d k=%0d: clock_out=%b tick=%b, expected %b %b",
                             bd[t], bh[t], k, clock_out, tick, exp_clk, exp_tick);
                end
            end
        end
    endtask

    task automatic test_random();
        int dv;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 15) == 0) en = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
            sync = ($urandom_range(0, 59) == 0);
            dv   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
            set_cfg(($urandom_range(0, 2) == 0), int'($urandom_range(0, NUM_CH - 1)),
                    dv, int'($urandom_range(0, dv + 2)));
            #1;
            n_vec++;
            if (cfg_if.cfg_ready !== model_ready(int'(cfg_if.cfg_ch))) begin
                n_err++;
                $display("FAIL random_ready k=%0d ch=%0d: cfg_ready=%b, expected %b",
                         k, cfg_if.cfg_ch, cfg_if.cfg_ready, model_ready(int'(cfg_if.cfg_ch)));
            end
            cycle();
            n_vec++;
            if (clock_out !== exp_clk || tick !== exp_tick) begin
                n_err++;
                $display("FAIL random_run k=%0d: clock_out=%b tick=%b, expected %b %b",
                         k, clock_out, tick, exp_clk, exp_tick);
            end
        end
        sync = 1'b0;
        set_cfg(1'b0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int guard;
        en = '0;
        set_cfg(1'b1, 0, 9, 4);
        cycle();
        set_cfg(1'b0, 0, 0, 0);
        cycle();
        en = 4'b0001;
        repeat (3) cycle();
        set_cfg(1'b1, 0, 3, 1);
        cycle();
        set_cfg(1'b0, 0, 0, 0);
        guard = 0;
        while (exp_clk[0] !== 1'b1 && guard < 20) begin
            cycle();
            guard++;
        end
        n_vec++;
        if (clock_out !== exp_clk || tick !== exp_tick) begin
            n_err++;
            $display("FAIL midrst_pre: clock_out=%b tick=%b, expected %b %b",
                     clock_out, tick, exp_clk, exp_tick);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (clock_out !== '0 || tick !== '0) begin
            n_err++;
            $display("FAIL midrst_async: clock_out=%b tick=%b, expected 0000 0000", clock_out, tick);
        end
        n_vec++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_ready: cfg_ready=%b, expected 1", cfg_if.cfg_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            n_vec++;
            if (clock_out !== exp_clk || tick !== exp_tick) begin
                n_err++;
                $display("FAIL midrst_run k=%0d: clock_out=%b tick=%b, expected %b %b",
                         k, clock_out, tick, exp_clk, exp_tick);
            end
        end
        #1;
        n_vec++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_ready_after: cfg_ready=%b, expected 1", cfg_if.cfg_ready);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_default_div();
        test_write_disabled();
        test_glitch_free();
        test_sync();
        test_boundaries();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
